// File: rtl/cordic_range_reduce.sv
// Argument reduction ahead of the CORDIC cosine pipeline: float32 radians in,
// |x| mod 2*pi folded into [0, pi/2] as Q1.26 plus a cosine negate flag out.
`timescale 1ns/1ps
module cordic_range_reduce #(
    parameter int MAX_EXP   = 6,
    parameter int FRAC_BITS = 26,
    parameter int OUT_W     = 28,
    parameter int RED_STEPS = MAX_EXP - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      dataa,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] angle,
    output logic             negate,
    output logic             err
);

    localparam int MAG_W = MAX_EXP + 1 + FRAC_BITS;
    localparam int K_W   = (RED_STEPS > 1) ? $clog2(RED_STEPS) : 1;

    // Truncated Q.26 constants; 3*pi/2 is built from them so the boundary lands exactly.
    localparam logic [MAG_W-1:0] HALF_PI       = MAG_W'(64'd105414357);
    localparam logic [MAG_W-1:0] PI            = MAG_W'(64'd210828714);
    localparam logic [MAG_W-1:0] TWO_PI        = MAG_W'(64'd421657428);
    localparam logic [MAG_W-1:0] THREE_HALF_PI = PI + HALF_PI;

    localparam logic [7:0] EXP_LIMIT = 8'(127 + MAX_EXP);
    localparam logic [7:0] EXP_Q     = 8'(127 + 23 - FRAC_BITS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CONVERT = 3'd1;
    localparam logic [2:0] S_REDUCE  = 3'd2;
    localparam logic [2:0] S_FOLD    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]       r_state;
    logic [K_W-1:0]   r_k;
    logic [7:0]       r_exp;
    logic [22:0]      r_frac;
    logic [MAG_W-1:0] r_mag;
    logic [OUT_W-1:0] r_angle;
    logic             r_negate;
    logic             r_err;

    logic             w_cvt_err;
    logic [MAG_W-1:0] w_step;

    // Float to fixed with truncation; denormals flush to zero.
    function automatic logic [MAG_W-1:0] f_to_mag(input logic [7:0] e, input logic [22:0] frac);
        logic [MAG_W-1:0] m;
        m = MAG_W'({1'b1, frac});
        if (e == 8'd0)
            return '0;
        if (e >= EXP_Q)
            return m << (e - EXP_Q);
        return m >> (EXP_Q - e);
    endfunction

    // Quadrant fold of r in [0, 2*pi); returns {negate, angle}.
    function automatic logic [OUT_W:0] f_fold(input logic [MAG_W-1:0] r);
        logic [OUT_W-2:0] a;
        logic             n;
        if (r <= HALF_PI) begin
            a = (OUT_W-1)'(r);
            n = 1'b0;
        end else if (r <= PI) begin
            a = (OUT_W-1)'(PI - r);
            n = 1'b1;
        end else if (r < THREE_HALF_PI) begin
            a = (OUT_W-1)'(r - PI);
            n = 1'b1;
        end else begin
            a = (OUT_W-1)'(TWO_PI - r);
            n = 1'b0;
        end
        return {n, 1'b0, a};
    endfunction

    assign w_cvt_err = (r_exp > EXP_LIMIT);
    assign w_step    = TWO_PI << r_k;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_angle  <= '0;
            r_negate <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid)
                        r_state <= S_CONVERT;
                end
                S_CONVERT: begin
                    r_err   <= w_cvt_err;
                    r_k     <= K_W'(RED_STEPS - 1);
                    r_state <= S_REDUCE;
                end
                S_REDUCE: begin
                    if (r_k == '0)
                        r_state <= S_FOLD;
                    else
                        r_k <= r_k - 1'b1;
                end
                S_FOLD: begin
                    {r_negate, r_angle} <= r_err ? '0 : f_fold(r_mag);
                    r_state             <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_err   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always rewritten before use.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    r_exp  <= dataa[30:23];
                    r_frac <= dataa[22:0];
                end
            end
            S_CONVERT: r_mag <= w_cvt_err ? '0 : f_to_mag(r_exp, r_frac);
            S_REDUCE: begin
                if (r_mag >= w_step)
                    r_mag <= r_mag - w_step;
            end
            default: ;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign angle     = r_angle;
    assign negate    = r_negate;
    assign err       = r_err;

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Scoreboard bench for cordic_range_reduce: directed angles with hand-computed results.
`timescale 1ns/1ps
module tb_cordic_range_reduce;

    localparam int LAT = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dataa = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [27:0] angle;
    logic        negate;
    logic        err;

    int     errors = 0;
    int     checks = 0;
    longint edges  = 0;

    typedef struct {
        logic [27:0] a;
        logic        n;
        logic        e;
        longint      acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;
    logic prev_vld = 1'b0;

    cordic_range_reduce dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataa     (dataa),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .angle     (angle),
        .negate    (negate),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: latency on the rising out_valid, payload on each accepted result.
    always @(negedge clk) begin
        if (out_valid && !prev_vld) begin
            if (sb.size() == 0)
                chk("unexpected_output", 64'd1, 64'd0);
            else
                chk("latency", 64'(edges - sb[0].acc), 64'(LAT));
        end
        if (out_valid && out_ready && sb.size() != 0) begin
            mon_x = sb.pop_front();
            chk("angle",  64'(angle),  64'(mon_x.a));
            chk("negate", 64'(negate), 64'(mon_x.n));
            chk("err",    64'(err),    64'(mon_x.e));
        end
        prev_vld = out_valid;
    end

    task automatic send(input logic [31:0] d, input logic [27:0] a, input logic n,
                        input logic e, input bit push);
        int   w;
        exp_t x;
        @(negedge clk);
        dataa    = d;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (push) begin
            x.a   = a;
            x.n   = n;
            x.e   = e;
            x.acc = edges;
            sb.push_back(x);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int w;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_angle",     64'(angle),     64'd0);
        chk("rst_negate",    64'(negate),    64'd0);
        chk("rst_err",       64'(err),       64'd0);
        rst = 1'b0;

        send(32'h3F000000, 28'd33554432, 1'b0, 1'b0, 1'b1); drain();   // 0.5
        send(32'h40000000, 28'd76610986, 1'b1, 1'b0, 1'b1); drain();   // 2.0
        send(32'hC0800000, 28'd57606742, 1'b1, 1'b0, 1'b1); drain();   // -4.0
        send(32'h40800000, 28'd57606742, 1'b1, 1'b0, 1'b1); drain();   // 4.0
        send(32'h42C80000, 28'd35632448, 1'b0, 1'b0, 1'b1); drain();   // 100.0
        send(32'h7F800000, 28'd0,        1'b0, 1'b1, 1'b1); drain();   // Inf
        send(32'h7FC00000, 28'd0,        1'b0, 1'b1, 1'b1); drain();   // NaN
        send(32'h43480000, 28'd0,        1'b0, 1'b1, 1'b1); drain();   // 200.0
        send(32'h00000000, 28'd0,        1'b0, 1'b0, 1'b1); drain();   // 0.0

        // Backpressure: result held, busy, and a new request ignored.
        out_ready = 1'b0;
        send(32'h3F000000, 28'd33554432, 1'b0, 1'b0, 1'b1);
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dataa    = 32'h40000000;
            chk("bp_valid",    64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready),  64'd0);
            chk("bp_angle",    64'(angle),     64'd33554432);
            chk("bp_negate",   64'(negate),    64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (15) @(negedge clk);
        chk("bp_no_extra_valid", 64'(out_valid), 64'd0);
        chk("bp_idle_ready",     64'(in_ready),  64'd1);

        // Reset in the middle of REDUCE aborts the request.
        send(32'h40000000, 28'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("busy_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready",   64'(in_ready),  64'd1);
        chk("abort_out_valid2", 64'(out_valid), 64'd0);
        send(32'h3F000000, 28'd33554432, 1'b0, 1'b0, 1'b1); drain();
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cordic_range_reduce.md
Name: cordic_range_reduce

Overview:
- Upstream argument-reduction stage for the CORDIC cosine pipeline.
- Takes an IEEE-754 single-precision angle in radians and computes r = |x| mod 2π with a multi-cycle compare-subtract sequence.
- Folds r into [0, π/2] and emits a 28-bit fixed-point angle plus a negate flag, so the downstream CORDIC always runs inside its convergence range. The consumer applies the negate flag to the final cosine.

Parameters:
MAX_EXP, 6, largest accepted unbiased exponent; |x| < 2^(MAX_EXP+1) (default |x| < 128)
FRAC_BITS, 26, fraction bits in internal and output fixed-point format
OUT_W, 28, output angle width: sign bit (always 0), 1 integer bit, FRAC_BITS fraction bits
RED_STEPS, MAX_EXP-1, number of compare-subtract steps; step j subtracts 2π·2^(RED_STEPS-1-j)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  dataa holds a valid request
in_ready  output  1  block can accept a request (IDLE only)
dataa  input  32  float32 angle in radians
out_valid  output  1  angle/negate/err are valid
out_ready  input  1  consumer accepts the result
angle  output  OUT_W  reduced angle in [0, π/2], unsigned value in the signed CORDIC format
negate  output  1  1 when cos(x) = -cos(angle)
err  output  1  input was NaN, Inf, or |x| ≥ 2^(MAX_EXP+1)

Behaviour:
- Reset (asynchronous, any state): state=IDLE, in_ready=1, out_valid=0, angle=0, negate=0, err=0.
- Internal magnitude register: unsigned, MAX_EXP+1 integer bits + FRAC_BITS fraction bits (33 bits at default).
- Constants at Q·26, truncated:
  - π/2 = 105414357
  - π = 210828714
  - 2π = 421657428
- FSM states: IDLE → CONVERT → REDUCE (RED_STEPS cycles, counter k from RED_STEPS-1 down to 0) → FOLD → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge, capture dataa and go to CONVERT.
  - in_ready is 0 in every other state. The block is not pipelined; one request is in flight at a time.
- CONVERT: sign bit ignored (cos is even). Let e = dataa[30:23] and mant = {1, dataa[22:0]}.
  - e == 255: set err=1, mag=0.
  - e > 127+MAX_EXP: set err=1, mag=0.
  - e == 0: mag=0 (denormals flush to zero).
  - e-127 ≥ -3: mag = mant << (e-124).
  - Otherwise: mag = mant >> (124-e); a result of zero is allowed.
  - Fraction bits below 2^-26 are truncated, never rounded.
- REDUCE, one step per cycle: if mag ≥ 2π·2^k then mag -= 2π·2^k. After the last step, 0 ≤ mag < 2π.
- FOLD, one cycle, with r = mag:
  - r ≤ π/2: angle=r, negate=0.
  - r ≤ π: angle=π-r, negate=1.
  - r < 3π/2: angle=r-π, negate=1.
  - Otherwise: angle=2π-r, negate=0.
  - Exact boundary values take the earlier branch. 3π/2 falls in the last branch and yields angle=π/2, negate=0.
  - If err=1, force angle=0, negate=0.
  - angle MSB is always 0.
- DONE:
  - out_valid=1; angle, negate and err are held stable while out_ready=0.
  - On out_ready=1 at an edge, out_valid drops, err clears, and state returns to IDLE.
- Latency: with acceptance edge E0, out_valid goes high after edge E(RED_STEPS+2), i.e. 7 edges at default. Minimum initiation interval is RED_STEPS+4 cycles.
- in_valid while busy is ignored. The upstream must hold dataa until in_ready is seen.
- Reset asserted mid-operation aborts the operation. No output is produced for the aborted request.

Test Plan:
- dataa=0x3F000000 (0.5), out_ready=1 → out_valid 7 edges after acceptance; angle=33554432 (0x2000000), negate=0, err=0.
- dataa=0x40000000 (2.0) → angle=76610986 (π-2), negate=1, err=0.
- dataa=0xC0800000 (-4.0) → angle=57606742 (4-π), negate=1; identical result for 0x40800000.
- dataa=0x42C80000 (100.0) → subtractions at k=3,2,1,0 (15·2π), r=386024980; angle=35632448, negate=0.
- dataa=0x7F800000 (Inf), 0x7FC00000 (NaN) and 0x43480000 (200.0) → err=1, angle=0, negate=0, same latency; dataa=0x00000000 → angle=0, err=0.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles with out_valid=1 → outputs stable, in_ready=0, new in_valid ignored.
  - Assert rst during REDUCE → out_valid=0 immediately and in_ready=1 after release.
  - The next request (0.5) then completes correctly.
